// File: rtl/serial_to_par8.sv
// Serial-to-parallel byte recovery: finds comma alignment in a 1-bit MSB-first
// stream, confirms it over LOCK_COUNT aligned commas, then emits one byte per 8 bits.
`timescale 1ns/1ps
module serial_to_par8 #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  localparam int unsigned BCW = ($clog2(LOCK_COUNT + 1) < 1) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [BCW-1:0] LOCK_TARGET = BCW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    SEARCH,
    LOCKING,
    ACTIVE
  } state_t;

  state_t         state, state_next;
  logic [7:0]     shift, shift_next;
  logic [2:0]     bit_cnt, bit_cnt_next;
  logic [BCW-1:0] bc_cnt, bc_cnt_next, bc_inc;
  logic [7:0]     data_next;
  logic           valid_next;
  logic           comma_hit;
  logic           boundary;

  assign shift_next = {shift[6:0], data_in};
  assign comma_hit  = (shift_next == COMMA);
  assign boundary   = (bit_cnt == 3'd7);
  assign bc_inc     = bc_cnt + BCW'(1);

  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt + 3'd1;
    bc_cnt_next  = bc_cnt;
    data_next    = data_out;
    valid_next   = valid_out;
    unique case (state)
      SEARCH: begin
        bit_cnt_next = '0;
        if (comma_hit) begin
          bc_cnt_next = BCW'(1);
          state_next  = (LOCK_TARGET <= BCW'(1)) ? ACTIVE : LOCKING;
        end
      end
      LOCKING: begin
        // Only aligned positions count; a mid-byte comma is ignored here.
        if (boundary) begin
          if (comma_hit) begin
            bc_cnt_next = bc_inc;
            if (bc_inc == LOCK_TARGET) state_next = ACTIVE;
          end else begin
            state_next   = SEARCH;
            bc_cnt_next  = '0;
            bit_cnt_next = '0;
          end
        end
      end
      ACTIVE: begin
        if (boundary) begin
          data_next  = shift_next;
          valid_next = !comma_hit;
        end
      end
      default: begin
        state_next   = SEARCH;
        bit_cnt_next = '0;
        bc_cnt_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state     <= SEARCH;
      shift     <= '0;
      bit_cnt   <= '0;
      bc_cnt    <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      state     <= state_next;
      shift     <= shift_next;
      bit_cnt   <= bit_cnt_next;
      bc_cnt    <= bc_cnt_next;
      data_out  <= data_next;
      valid_out <= valid_next;
      active    <= (state_next == ACTIVE);
    end
  end

endmodule

// File: tb/tb_serial_to_par8.sv
// Scoreboard bench for serial_to_par8: expected bytes are queued as they are
// serialised and popped whenever the recovered outputs change.
`timescale 1ns/1ps
module tb_serial_to_par8;

  localparam logic [7:0] COMMA = 8'hBC;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b1;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  serial_to_par8 #(.COMMA(8'hBC), .LOCK_COUNT(4)) dut (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .active   (active)
  );

  always #5 clk_32f = ~clk_32f;

  typedef struct {
    logic [7:0] data;
    logic       valid;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  logic       byte_end = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_valid = 1'b0;

  // Output monitor: any change must land on a byte boundary and match the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_32f);
      #1;
      if (reset) begin
        prev_data  = data_out;
        prev_valid = valid_out;
      end else if (data_out !== prev_data || valid_out !== prev_valid) begin
        total++;
        if (!byte_end) begin
          bad++;
          $display("FAIL boundary_only: data_out %h->%h changed off a byte boundary, required hold", prev_data, data_out);
        end
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output: got data_out=%h valid_out=%b, required no change", data_out, valid_out);
        end else begin
          e = sb.pop_front();
          if (data_out !== e.data || valid_out !== e.valid) begin
            bad++;
            $display("FAIL byte_out: got data_out=%h valid_out=%b, required data_out=%h valid_out=%b",
                     data_out, valid_out, e.data, e.valid);
          end
        end
        prev_data  = data_out;
        prev_valid = valid_out;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    data_in = b;
    @(posedge clk_32f);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit expect_out);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk_32f);
      data_in = b[i];
      if (i == 0) begin
        byte_end = 1'b1;
        if (expect_out) sb.push_back('{data: b, valid: (b != COMMA)});
      end
      @(posedge clk_32f);
      #2;
      byte_end = 1'b0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk_32f);
    reset = 1'b1;
    sb.delete();
    repeat (3) @(negedge clk_32f);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk_32f);
    reset = 1'b1;
    #1;
    total++;
    if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data: got %h, required 00", data_out); end
    total++;
    if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b, required 0", valid_out); end
    total++;
    if (active !== 1'b0) begin bad++; $display("FAIL reset_active: got %b, required 0", active); end
    repeat (3) @(negedge clk_32f);
    reset = 1'b0;
  endtask

  task automatic test_lock_and_data();
    apply_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    for (int k = 1; k <= 4; k++) begin
      send_byte(COMMA, 1'b0);
      total++;
      if (active !== (k == 4)) begin
        bad++;
        $display("FAIL lock_active_bc%0d: got %b, required %b", k, active, (k == 4));
      end
    end
    total++;
    if (data_out !== 8'h00 || valid_out !== 1'b0) begin
      bad++;
      $display("FAIL lock_entry_outputs: got data_out=%h valid_out=%b, required 00/0", data_out, valid_out);
    end
    send_byte(8'h5A, 1'b1);
    send_byte(8'hC3, 1'b1);
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL lock_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_lock_loss();
    apply_reset();
    send_byte(COMMA, 1'b0);
    send_byte(COMMA, 1'b0);
    send_byte(8'h11, 1'b0);
    total++;
    if (active !== 1'b0) begin bad++; $display("FAIL loss_active: got %b, required 0", active); end
    for (int k = 1; k <= 4; k++) begin
      send_byte(COMMA, 1'b0);
      total++;
      if (active !== (k == 4)) begin
        bad++;
        $display("FAIL relock_active_bc%0d: got %b, required %b", k, active, (k == 4));
      end
    end
    send_byte(8'h22, 1'b1);
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL loss_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_comma_in_stream();
    apply_reset();
    repeat (4) send_byte(COMMA, 1'b0);
    send_byte(8'h33, 1'b1);
    send_byte(COMMA, 1'b1);
    send_byte(8'h44, 1'b1);
    total++;
    if (active !== 1'b1) begin bad++; $display("FAIL stream_active: got %b, required 1", active); end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL stream_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_unaligned();
    logic [2:0] pad;
    apply_reset();
    send_byte(COMMA, 1'b0);
    for (int n = 0; n < 24; n++) begin
      pad = 3'($urandom_range(0, 7));
      for (int j = 2; j >= 0; j--) send_bit(pad[j]);
      send_byte(COMMA, 1'b0);
      total++;
      if (active !== 1'b0 || valid_out !== 1'b0) begin
        bad++;
        $display("FAIL unaligned_%0d: got active=%b valid_out=%b, required 0/0", n, active, valid_out);
      end
    end
  endtask

  task automatic test_reset_mid_active();
    logic [7:0] partial;
    partial = 8'h96;
    apply_reset();
    repeat (4) send_byte(COMMA, 1'b0);
    send_byte(8'h5A, 1'b1);
    total++;
    if (active !== 1'b1 || valid_out !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_state: got active=%b valid_out=%b, required 1/1", active, valid_out);
    end
    for (int j = 7; j >= 4; j--) send_bit(partial[j]);
    #1;
    reset = 1'b1;
    #1;
    total++;
    if (data_out !== 8'h00 || valid_out !== 1'b0 || active !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got data_out=%h valid_out=%b active=%b, required 00/0/0",
               data_out, valid_out, active);
    end
    repeat (3) @(posedge clk_32f);
    @(negedge clk_32f);
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      send_byte(COMMA, 1'b0);
      total++;
      if (active !== (k == 4)) begin
        bad++;
        $display("FAIL post_reset_lock_bc%0d: got %b, required %b", k, active, (k == 4));
      end
    end
    send_byte(8'h77, 1'b1);
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL post_reset_drain: got %0d pending, required 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_lock_and_data();
    test_lock_loss();
    test_comma_in_stream();
    test_unaligned();
    test_reset_mid_active();
    repeat (4) @(posedge clk_32f);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
